uart_rx_ctrl: RTL



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_ctrl_if.sv | 13 +
 rtl/rx_clk.sv | 51 +++++
 rtl/uart_rx_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, tick constants and small helper functions for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [3:0] SMP_PER_BIT      = 4'd9;
  localparam logic [3:0] VOTE_T0          = 4'd4;
  localparam logic [3:0] VOTE_T1          = 4'd5;
  localparam logic [3:0] VOTE_T2          = 4'd6;
  localparam logic [3:0] STOP_DECIDE_TICK = 4'd6;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-byte interface between the UART receive controller and the UART top level.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (output rx_data, output rx_valid, output frame_err, output parity_err, output busy);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  parity_err, input  busy);
endinterface

// File: rtl/rx_clk.sv
// Oversampling tick generator: while enabled, emits one sample_clk pulse per 1/9 bit period.
module rx_clk
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_start,
  input  logic rx_done,
  output logic sample_clk
);

  localparam int DIV = CLK_FREQUENCE / (BAUD_RATE * int'(SMP_PER_BIT));
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          r_en;
  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider restarts on rx_start so the first tick lands one full tick period after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (rx_start) begin
        r_en  <= 1'b1;
        r_cnt <= '0;
      end else if (rx_done) begin
        r_en  <= 1'b0;
        r_cnt <= '0;
      end else if (r_en) begin
        if (r_cnt == CW'(DIV - 1)) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign sample_clk = r_tick;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-edge detect, 3-of-9 majority vote, LSB-first shift, stop check.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_BITS     = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD    = 1'b0
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  uart_rx_ctrl_if.master rx_if
);

  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_d;
  rx_state_t            r_state;
  logic [3:0]           r_tick_cnt;
  logic [2:0]           r_bit_cnt;
  logic [2:0]           r_smp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_rx_start;
  logic                 r_rx_done;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_parity_err;
`endif

  logic       w_fall;
  logic       w_tick;
  logic [3:0] w_tick_num;
  logic       w_bit_end;
  logic       w_bit_vote;
  logic       w_stop_vote;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  assign w_fall      = r_rx_d & ~r_rx_s;
  assign w_tick_num  = r_tick_cnt + 4'd1;
  assign w_bit_end   = w_tick && (w_tick_num == SMP_PER_BIT);
  assign w_bit_vote  = maj3(r_smp[0], r_smp[1], r_smp[2]);
  // The stop decision happens on tick 6 itself, so the third sample is the live line.
  assign w_stop_vote = maj3(r_smp[0], r_smp[1], r_rx_s);

  rx_clk #(
    .CLK_FREQUENCE(CLK_FREQUENCE),
    .BAUD_RATE    (BAUD_RATE)
  ) u_rx_clk (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_start  (r_rx_start),
    .rx_done   (r_rx_done),
    .sample_clk(w_tick)
  );

  // Receive FSM with tick counting, voting samples and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_smp       <= 3'b000;
      r_shift     <= '0;
      r_rx_start  <= 1'b0;
      r_rx_done   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_start  <= 1'b0;
      r_rx_done   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (w_tick && (r_state != IDLE)) begin
        r_tick_cnt <= (w_tick_num == SMP_PER_BIT) ? 4'd0 : w_tick_num;
        if (w_tick_num == VOTE_T0) r_smp[0] <= r_rx_s;
        if (w_tick_num == VOTE_T1) r_smp[1] <= r_rx_s;
        if (w_tick_num == VOTE_T2) r_smp[2] <= r_rx_s;
      end
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_rx_start <= 1'b1;
            r_tick_cnt <= 4'd0;
            r_busy     <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            if (w_bit_vote) begin
              r_rx_done <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= 3'd0;
              r_state   <= DATA;
            end
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift   <= {w_bit_vote, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_par_bit <= w_bit_vote;
            r_state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick && (w_tick_num == STOP_DECIDE_TICK)) begin
            if (w_stop_vote) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            r_parity_err <= ((parity8(8'(r_shift)) ^ r_par_bit) != PARITY_ODD);
`endif
            r_rx_done <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_if.rx_data   = r_rx_data;
  assign rx_if.rx_valid  = r_rx_valid;
  assign rx_if.frame_err = r_frame_err;
  assign rx_if.busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = r_parity_err;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule
